// File: rtl/dec_sel_sequencer.sv
// Timed select-code sequencer that drives the 3-to-8 decoder's din.
// Walks codes up, down, once, or holds, with a programmable per-code dwell.
module dec_sel_sequencer #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [1:0]         mode_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               sel_ready_i,
  output logic [SEL_W-1:0]   sel_out_o,
  output logic               sel_valid_o,
  output logic               busy_o,
  output logic               wrap_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b10;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         mode_q, mode_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mode_q  <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  // Stop always takes priority; mode and dwell are only sampled on launch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d = RUN;
          mode_d  = mode_i;
          dwell_d = dwell_i;
          sel_d   = (mode_i == MODE_DOWN) ? '1 : '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (cnt_q < dwell_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (sel_ready_i) begin
          cnt_d = '0;
          case (mode_q)
            MODE_UP: begin
              sel_d  = sel_q + 1'b1;
              wrap_d = (sel_q == '1);
            end
            MODE_DOWN: begin
              sel_d  = sel_q - 1'b1;
              wrap_d = (sel_q == '0);
            end
            MODE_ONCE: begin
              if (sel_q == '1) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                sel_d = sel_q + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_out_o   = sel_q;
  assign sel_valid_o = (state_q == RUN);
  assign busy_o      = (state_q != IDLE);
  assign wrap_o      = wrap_q;
  assign done_o      = done_q;

endmodule
